// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Round-robin sharing of the block-wide Data_Memory port between the
//            I-cache refill path and the D-cache controller (refill/writeback).
//            Optional grant/conflict counters: define MEM_ARB_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 32,
    parameter int BLK_W   = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ack,
    output logic [BLK_W-1:0]  ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [BLK_W-1:0]  dc_wdata,
    output logic              dc_ack,
    output logic [BLK_W-1:0]  dc_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BLK_W-1:0]  mem_wdata,
`ifdef MEM_ARB_PERF_CNT_EN
    output logic [15:0]       ic_grant_cnt,
    output logic [15:0]       dc_grant_cnt,
    output logic [15:0]       conflict_cnt,
`endif
    input  logic [BLK_W-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic       c_GNT_IC = 1'b0;
    localparam logic       c_GNT_DC = 1'b1;
    localparam logic [3:0] c_LAT_M1 = 4'(MEM_LAT - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_winner;
    logic        r_last;
    logic        r_op_we;

    logic              w_any;
    logic              w_both;
    logic              w_winner;
    logic              w_win_we;
    logic [ADDR_W-1:0] w_addr;

    // On a tie the requester that did not win last time gets the port.
    assign w_any    = ic_req | dc_req;
    assign w_both   = ic_req & dc_req;
    assign w_winner = w_both ? ~r_last : dc_req;
    assign w_win_we = (w_winner == c_GNT_DC) & dc_we;
    assign w_addr   = (w_winner == c_GNT_DC) ? dc_addr : ic_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_winner  <= c_GNT_IC;
            r_last    <= c_GNT_DC;
            r_op_we   <= 1'b0;
            ic_ack    <= 1'b0;
            dc_ack    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ic_rdata  <= '0;
            dc_rdata  <= '0;
`ifdef MEM_ARB_PERF_CNT_EN
            ic_grant_cnt <= 16'd0;
            dc_grant_cnt <= 16'd0;
            conflict_cnt <= 16'd0;
`endif
        end else begin
            ic_ack <= 1'b0;
            dc_ack <= 1'b0;
            mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_winner <= w_winner;
                        r_last   <= w_winner;
                        r_op_we  <= w_win_we;
                        mem_addr <= {w_addr[ADDR_W-1:6], 6'b0};
                        if (w_win_we) begin
                            mem_wdata <= dc_wdata;
                        end
                        r_cnt   <= c_LAT_M1;
                        // Write strobe is registered, so it is armed one cycle ahead.
                        mem_we  <= w_win_we && (c_LAT_M1 == 4'd0);
                        r_state <= ACCESS;
`ifdef MEM_ARB_PERF_CNT_EN
                        if (w_winner == c_GNT_IC && ic_grant_cnt != 16'hFFFF) begin
                            ic_grant_cnt <= ic_grant_cnt + 16'd1;
                        end
                        if (w_winner == c_GNT_DC && dc_grant_cnt != 16'hFFFF) begin
                            dc_grant_cnt <= dc_grant_cnt + 16'd1;
                        end
                        if (w_both && conflict_cnt != 16'hFFFF) begin
                            conflict_cnt <= conflict_cnt + 16'd1;
                        end
`endif
                    end
                end
                ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_op_we) begin
                            if (r_winner == c_GNT_DC) begin
                                dc_rdata <= mem_rdata;
                            end else begin
                                ic_rdata <= mem_rdata;
                            end
                        end
                        if (r_winner == c_GNT_DC) begin
                            dc_ack <= 1'b1;
                        end else begin
                            ic_ack <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt  <= r_cnt - 4'd1;
                        mem_we <= r_op_we && (r_cnt == 4'd1);
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
